rv_plic_gateway: RTL and testbench
==================================

Name: rv_plic_gateway

Overview:
Source-side front end of the PLIC that feeds the per-target priority/threshold arbiter. It converts raw peripheral interrupt lines into per-source pending bits (ip_o), in level or edge mode per source. It also implements the claim/complete handshake from the hart-facing register block. A claimed source is held in-service and is not re-pended until its completion arrives.

Parameters:
N_SOURCE, 37, number of interrupt sources; minimum 2.
SrcWidth, $clog2(N_SOURCE+1), localparam; width of the source ID fields.

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset; synchronous, active-high.
src_i  input  N_SOURCE  raw interrupt lines, active-high, already in the clk_i domain unless the optional synchronizer is enabled.
le_i  input  N_SOURCE  per-source mode: 1 = edge-triggered, 0 = level-triggered.
claim_i  input  1  one-cycle claim strobe.
claim_id_i  input  SrcWidth  ID of the source being claimed.
complete_i  input  1  one-cycle complete strobe.
complete_id_i  input  SrcWidth  ID of the source being completed.
ip_o  output  N_SOURCE  pending bits, registered, sent to the arbiter.
ia_o  output  N_SOURCE  in-service (active) bits, registered, for debug/status.

Behaviour:
- The ID equals the source bit index. Any ID >= N_SOURCE on claim or complete is ignored with no state change.
- State per source:
  - ip_q: pending.
  - ia_q: in service.
  - ep_q: one-deep deferred edge.
  - src_q: previous source sample.
- Reset (rst_i=1 at a rising edge): ip_q, ia_q, ep_q and src_q all clear to 0, so ip_o=0 and ia_o=0.
  - Because src_q resets to 0, a source that is high when reset is released counts as a rising edge in edge mode.
- Reset asserted mid-operation discards all pending, in-service and deferred state in that cycle. No completion is needed afterwards.
- Edge detection: edge[i] = src_i[i] & ~src_q[i]. src_q <= src_i every cycle.
- Set condition:
  - Level mode: set[i] = src_i[i] & ~ip_q[i] & ~ia_q[i].
  - Edge mode: set[i] = (edge[i] | ep_q[i]) & ~ip_q[i] & ~ia_q[i].
  - Latency: src_i high at clock edge n gives ip_o high after edge n (1 cycle).
- Deferred edge (edge mode only):
  - An edge arriving while ip_q[i] or ia_q[i] is set sets ep_q[i]. Further edges are coalesced (one deep).
  - ep_q[i] clears in the cycle it produces a set.
  - ep_q[i] is forced to 0 whenever le_i[i]=0.
- Claim: if claim_i and ip_q[id]=1, then ip_q[id] <= 0 and ia_q[id] <= 1. A claim of a non-pending source is ignored.
- Complete: if complete_i and ia_q[id]=1, then ia_q[id] <= 0. A complete of a non-active source is ignored.
- Claim and complete in the same cycle are evaluated independently against registered state.
  - Same ID: the invariant ~(ip_q & ia_q) guarantees at most one of them takes effect.
  - Different IDs: both take effect.
- Re-pend after complete: earliest is the cycle after ia clears.
  - Level mode: re-pends if src_i is still high.
  - Edge mode: re-pends if ep_q is set.
- Level mode: src_i deasserting while ip_q=1 does not clear ip_q. Pending is sticky until claimed.
- A change of le_i takes effect on the next clock. It does not alter existing ip_q or ia_q.
- Invariant: ip_q[i] & ia_q[i] is never 1. An assertion checks this.

Optional Feature:
Macro: RV_PLIC_GW_SYNC_EN.
- Defined: each src_i bit passes through a 2-flop synchronizer (reset to 0) before edge detection and the set logic. Source-to-ip_o latency becomes 3 cycles.
- Undefined: src_i is used directly, with 1-cycle latency. No synchronizer flops exist.

Test Plan:
1. Level mode:
   - Stimulus: le_i=0, src_i[5]=1 held, claim id 5, then complete id 5.
   - Response: ip_o[5]=1 after 1 cycle. Claim gives ip_o[5]=0 and ia_o[5]=1. Complete gives ia_o[5]=0, and ip_o[5]=1 again on the following cycle.
2. Edge mode with deferral:
   - Stimulus: le_i[3]=1, one-cycle pulse on src_i[3], claim id 3, then two more pulses while in service, then complete.
   - Response: ip_o[3]=1 then cleared by the claim. The two pulses coalesce into ep. After complete, ip_o[3]=1 exactly once, and no further pend without a new edge.
3. Invalid and ignored operations:
   - Stimulus: claim id 7 with ip_o[7]=0; complete id 9 with ia_o[9]=0; claim id 40 with N_SOURCE=37.
   - Response: ip_o and ia_o are unchanged in every case.
4. Simultaneous claim and complete:
   - Stimulus: sources 1 and 2 both pending, source 1 claimed. Next cycle: claim id 2 and complete id 1 together.
   - Response: ia_o[1]=0, ia_o[2]=1, ip_o[2]=0.
5. Reset mid-service:
   - Stimulus: ia_o[4]=1, ep set on source 4, rst_i=1 for one cycle, src_i[4]=0.
   - Response: ip_o, ia_o and ep are all 0 after reset. Source 4 stays idle until a new edge.
6. With RV_PLIC_GW_SYNC_EN defined:
   - Stimulus: src_i[0] rises at cycle 10, level mode.
   - Response: ip_o[0] rises after cycle 12's clock edge (3-cycle latency). Without the macro it rises after cycle 10's edge.

Source files
------------

// File: rtl/rv_plic_gateway.sv
// rv_plic_gateway
//   Source-side front end of the PLIC. Turns raw peripheral interrupt lines
//   into per-source pending bits (level or edge mode per source) and runs the
//   claim/complete handshake. A claimed source stays in service and cannot
//   re-pend until its completion arrives.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   src_i          raw interrupt lines, active-high
//   le_i           per-source mode: 1 = edge, 0 = level
//   claim_i        one-cycle claim strobe
//   claim_id_i     ID (bit index) of the source being claimed
//   complete_i     one-cycle complete strobe
//   complete_id_i  ID (bit index) of the source being completed
//   ip_o           registered pending bits to the arbiter
//   ia_o           registered in-service bits (status/debug)
//
// Configuration
//   RV_PLIC_GW_SYNC_EN  when defined, every src_i bit passes through a 2-flop
//                       synchronizer, so source-to-ip_o latency is 3 cycles
//                       instead of 1.
//
// Handshake: claim_i and complete_i are single-cycle strobes with no ready;
// each acts only when its target bit is in the right state (claim needs
// ip_q=1, complete needs ia_q=1), otherwise it is dropped without effect.
// IDs >= N_SOURCE never decode to a source and are therefore ignored.

module rv_plic_gateway #(
   parameter int  N_SOURCE = 37,
   localparam int SrcWidth = $clog2(N_SOURCE + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_SOURCE-1:0] src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic                claim_i,
   input  logic [SrcWidth-1:0] claim_id_i,
   input  logic                complete_i,
   input  logic [SrcWidth-1:0] complete_id_i,
   output logic [N_SOURCE-1:0] ip_o,
   output logic [N_SOURCE-1:0] ia_o
);

   logic [N_SOURCE-1:0] ip_q, ia_q, ep_q, src_q;
   logic [N_SOURCE-1:0] ip_d, ia_d, ep_d;
   logic [N_SOURCE-1:0] src_s;
   logic [N_SOURCE-1:0] edge_det, trig, set_v;
   logic [N_SOURCE-1:0] claim_hit, complete_hit;

`ifdef RV_PLIC_GW_SYNC_EN
   logic [N_SOURCE-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src_i;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src_i;
`endif

   // src_q resets to 0, so a source already high when reset releases is
   // seen as a rising edge in edge mode.
   assign edge_det = src_s & ~src_q;

   // Edge-mode sources also fire from a deferred edge held in ep_q.
   assign trig  = (le_i & (edge_det | ep_q)) | (~le_i & src_s);
   assign set_v = trig & ~ip_q & ~ia_q;

   // Claim and complete are decoded independently against registered state.
   // Since ip_q and ia_q are never both set, a same-ID claim+complete can
   // have at most one effect.
   always_comb begin
      claim_hit    = '0;
      complete_hit = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         claim_hit[i]    = claim_i    && (claim_id_i    == SrcWidth'(i)) && ip_q[i];
         complete_hit[i] = complete_i && (complete_id_i == SrcWidth'(i)) && ia_q[i];
      end
   end

   // set_v needs ip_q=0 while claim_hit needs ip_q=1, so they never collide.
   assign ip_d = (ip_q & ~claim_hit) | set_v;
   assign ia_d = (ia_q & ~complete_hit) | claim_hit;

   // One-deep deferred edge: captured when an edge finds the source busy,
   // consumed by the set it produces, and held at 0 in level mode.
   assign ep_d = le_i & ((ep_q & ~set_v) | (edge_det & (ip_q | ia_q)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ip_q  <= '0;
         ia_q  <= '0;
         ep_q  <= '0;
         src_q <= '0;
      end else begin
         ip_q  <= ip_d;
         ia_q  <= ia_d;
         ep_q  <= ep_d;
         src_q <= src_s;
      end
   end

   assign ip_o = ip_q;
   assign ia_o = ia_q;

`ifndef SYNTHESIS
   // A source is never pending and in service at the same time.
   a_ip_ia_exclusive : assert property (
      @(posedge clk_i) disable iff (rst_i) ((ip_q & ia_q) == '0)
   );
`endif

endmodule

// File: tb/tb_rv_plic_gateway.sv
module tb_rv_plic_gateway;

   localparam int N  = 37;
   localparam int SW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  src;
   logic [N-1:0]  le;
   logic          claim;
   logic [SW-1:0] claim_id;
   logic          complete;
   logic [SW-1:0] complete_id;
   logic [N-1:0]  ip_o;
   logic [N-1:0]  ia_o;

   int checks   = 0;
   int failures = 0;

   // Reference model state, one entry per source.
   logic [N-1:0] m_ip, m_ia, m_ep, m_prev;
   logic [N-1:0] m_s1, m_s2;

   rv_plic_gateway #(.N_SOURCE(N)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .src_i         (src),
      .le_i          (le),
      .claim_i       (claim),
      .claim_id_i    (claim_id),
      .complete_i    (complete),
      .complete_id_i (complete_id),
      .ip_o          (ip_o),
      .ia_o          (ia_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Applies the gateway rules for one clock edge to the model, using the
   // inputs as they stand at that edge.
   task automatic model_step();
      logic [N-1:0] s;
      bit rise, fire, busy;
      if (rst) begin
         m_ip = '0; m_ia = '0; m_ep = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
         return;
      end
`ifdef RV_PLIC_GW_SYNC_EN
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = src;
`else
      s = src;
`endif
      for (int i = 0; i < N; i++) begin
         rise = s[i] && !m_prev[i];
         busy = m_ip[i] || m_ia[i];
         if (le[i]) fire = (rise || m_ep[i]) && !busy;
         else       fire = s[i] && !busy;
         // deferred edge bookkeeping
         if (!le[i])              m_ep[i] = 1'b0;
         else if (fire)           m_ep[i] = 1'b0;
         else if (rise && busy)   m_ep[i] = 1'b1;
         // pending / in-service
         if (fire) m_ip[i] = 1'b1;
         else if (claim && int'(claim_id) == i && m_ip[i]) begin
            m_ip[i] = 1'b0;
            m_ia[i] = 1'b1;
         end else if (complete && int'(complete_id) == i && m_ia[i])
            m_ia[i] = 1'b0;
         m_prev[i] = s[i];
      end
   endtask

   // ---------------- driver ----------------
   // One clock: advance model, take the edge, sample #1 later, compare.
   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check("ip_model", 64'(ip_o), 64'(m_ip));
      check("ia_model", 64'(ia_o), 64'(m_ia));
      claim    = 1'b0;
      complete = 1'b0;
   endtask

   task automatic do_claim(input int id);
      claim = 1'b1; claim_id = SW'(id);
      cyc();
   endtask

   task automatic do_complete(input int id);
      complete = 1'b1; complete_id = SW'(id);
      cyc();
   endtask

   function automatic int pick(input logic [N-1:0] v);
      int start;
      start = $urandom_range(0, N - 1);
      for (int k = 0; k < N; k++)
         if (v[(start + k) % N]) return (start + k) % N;
      return $urandom_range(0, 63);
   endfunction

   // ---------------- stimulus ----------------
   logic [N-1:0] snap_ip, snap_ia;

   initial begin
      rst = 1'b1; src = '0; le = '0;
      claim = 1'b0; claim_id = '0; complete = 1'b0; complete_id = '0;
      m_ip = '0; m_ia = '0; m_ep = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      #2;
      cyc();
      cyc();
      check("reset_ip", 64'(ip_o), 64'd0);
      check("reset_ia", 64'(ia_o), 64'd0);
      rst = 1'b0;

      // Level mode on source 5
      le = '0; src[5] = 1'b1;
      cyc();
      check("lvl_pend", 64'(ip_o[5]), 64'd1);
      do_claim(5);
      check("lvl_claim_ip", 64'(ip_o[5]), 64'd0);
      check("lvl_claim_ia", 64'(ia_o[5]), 64'd1);
      do_complete(5);
      check("lvl_cmpl_ia", 64'(ia_o[5]), 64'd0);
      check("lvl_cmpl_ip_same", 64'(ip_o[5]), 64'd0);
      cyc();
      check("lvl_repend", 64'(ip_o[5]), 64'd1);
      src[5] = 1'b0;
      cyc();
      check("lvl_sticky", 64'(ip_o[5]), 64'd1);
      do_claim(5);
      do_complete(5);
      cyc();

      // Edge mode with deferral on source 3
      le[3] = 1'b1; src[3] = 1'b1;
      cyc();
      check("edge_pend", 64'(ip_o[3]), 64'd1);
      src[3] = 1'b0;
      do_claim(3);
      check("edge_claim_ia", 64'(ia_o[3]), 64'd1);
      src[3] = 1'b1; cyc();
      src[3] = 1'b0; cyc();
      src[3] = 1'b1; cyc();
      src[3] = 1'b0; cyc();
      check("edge_no_pend_busy", 64'(ip_o[3]), 64'd0);
      do_complete(3);
      check("edge_cmpl_ip_same", 64'(ip_o[3]), 64'd0);
      cyc();
      check("edge_deferred", 64'(ip_o[3]), 64'd1);
      do_claim(3);
      do_complete(3);
      cyc(); cyc();
      check("edge_coalesced", 64'(ip_o[3]), 64'd0);

      // Ignored operations
      snap_ip = ip_o; snap_ia = ia_o;
      do_claim(7);
      check("ign_claim7_ip", 64'(ip_o), 64'(snap_ip));
      check("ign_claim7_ia", 64'(ia_o), 64'(snap_ia));
      do_complete(9);
      check("ign_cmpl9_ia", 64'(ia_o), 64'(snap_ia));
      do_claim(40);
      check("ign_claim40_ip", 64'(ip_o), 64'(snap_ip));
      check("ign_claim40_ia", 64'(ia_o), 64'(snap_ia));

      // Simultaneous claim and complete on different IDs
      src[1] = 1'b1; src[2] = 1'b1;
      cyc();
      src[1] = 1'b0; src[2] = 1'b0;
      do_claim(1);
      claim = 1'b1; claim_id = SW'(2);
      complete = 1'b1; complete_id = SW'(1);
      cyc();
      check("sim_ia1", 64'(ia_o[1]), 64'd0);
      check("sim_ia2", 64'(ia_o[2]), 64'd1);
      check("sim_ip2", 64'(ip_o[2]), 64'd0);
      do_complete(2);

      // Reset mid-service with a deferred edge on source 4
      le[4] = 1'b1; src[4] = 1'b1;
      cyc();
      src[4] = 1'b0;
      do_claim(4);
      src[4] = 1'b1; cyc();
      src[4] = 1'b0;
      rst = 1'b1; cyc();
      rst = 1'b0;
      check("rst_mid_ip", 64'(ip_o), 64'd0);
      check("rst_mid_ia", 64'(ia_o), 64'd0);
      cyc(); cyc(); cyc();
      check("rst_mid_idle4", 64'(ip_o[4]), 64'd0);
      src[4] = 1'b1; cyc();
      check("rst_mid_new_edge", 64'(ip_o[4]), 64'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 1) == 0)
            src = N'({$urandom, $urandom} & {$urandom, $urandom});
         if ($urandom_range(0, 40) == 0) le = N'({$urandom, $urandom});
         if ($urandom_range(0, 2) != 0) begin
            claim    = 1'b1;
            claim_id = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(0, 63)) : SW'(pick(m_ip));
         end
         if ($urandom_range(0, 2) != 0) begin
            complete    = 1'b1;
            complete_id = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(0, 63)) : SW'(pick(m_ia));
         end
         rst = ($urandom_range(0, 150) == 0);
         cyc();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
